mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, four-slave request arbiter between the CPU instruction port (imemory) and data port (dmemory) and the iram, dram, uart and timer slaves. It decodes each request's address against the shared address map and buffers requests that cannot issue immediately. It grants each slave to one master at a time with round-robin fairness and routes the slave's response back to its owning master. Unlike a plain combinational mux, a slow slave (uart) is held by exactly one master until it responds, and the other master is never dropped or starved.

## Interface
- NSLV, 4: number of slaves. Index 0 = iram, 1 = dram, 2 = uart, 3 = timer.
- clk_pll  in  1  system clock
- rst  in  1  reset; synchronous, active-low; clock clk_pll
- m_valid  in  [2]  request pulse. Index 0 = instruction master, 1 = data master.
- m_instr  in  [2]  instruction-fetch qualifier
- m_addr  in  [2][32]  byte address
- m_wdata  in  [2][32]  write data
- m_wstrb  in  [2][4]  byte strobes; 0 = read
- m_rdata  out  [2][32]  response data, valid with m_ready
- m_ready  out  [2]  response pulse
- s_valid  out  [NSLV]  request pulse to slave
- s_instr, s_addr[32], s_wdata[32], s_wstrb[4]  out  per slave  forwarded fields. s_addr = m_addr XOR slave base.
- s_rdata  in  [NSLV][32]  slave response data
- s_ready  in  [NSLV]  slave response pulse

## Operation
- Protocol: m_valid is a single-cycle pulse. Each master has at most one outstanding request and issues no new m_valid before its m_ready. s_valid and s_ready are single-cycle pulses.
- Decode: compare m_addr against slv_base_addr[k] ≤ addr < slv_top_addr[k]. Priority on match is timer, uart, dram, iram. No match = unmapped.
- Per-master FSM:
  - IDLE: on m_valid, unmapped goes to ERR; a winning free slave goes to BUSY; otherwise latch instr/addr/wdata/wstrb into the request buffer and go to PEND.
  - PEND: drive the buffered request into arbitration every cycle. On a win, go to BUSY.
  - BUSY(k): wait for s_ready[k], then go to IDLE.
  - ERR: pulse m_ready with m_rdata = 0, then go to IDLE.
- Per-slave state: owner (none/0/1) and a last-grant bit.
  - A slave is grantable only when owner = none.
  - When both masters request the same grantable slave in the same cycle (live pulse or PEND), the master other than last-grant wins. last-grant then updates to the winner.
  - An uncontended grant also updates last-grant.
- Grant drives s_valid[k] and the forwarded fields from the live inputs or the buffer, sets owner = winner, and leaves the loser in PEND.
- Response: s_ready[k] with owner = m drives m_ready[m] and m_rdata[m] = s_rdata[k] combinationally, and clears owner. s_ready with owner = none is ignored.
- Non-conflicting requests (different slaves) issue in the same cycle.
- Reset values:
  - All masters IDLE, all owners none, last-grant = 0 (data master wins the first conflict), buffers 0.
  - Outputs: m_ready = 0, m_rdata = 0, s_valid = 0, forwarded fields 0 when not granted.

## Timing
- Uncontended request: s_valid in the same cycle as m_valid (zero added latency). m_ready in the same cycle as s_ready.
- Loser of a conflict, or a request to a busy slave: s_valid no earlier than the cycle after the owner's s_ready. A slave freed by s_ready in cycle t is re-grantable at t+1, not in t.
- Unmapped: m_ready exactly one cycle after m_valid.
- Simultaneous events:
  - s_ready for master A and a new m_valid from A in the same cycle is a protocol violation and is not handled.
  - s_ready[k] and m_valid for k from the other master in the same cycle: the request goes to PEND and issues at t+1.
- Reset mid-transaction:
  - All state clears on the next clk_pll edge with rst = 0.
  - In-flight responses arriving after reset produce no m_ready.

## Structure
- slv_base_addr and slv_top_addr arrays, the slave index localparams and the master FSM enum belong in configure.
- These arrays are built from the existing iram_, dram_, uart_ and timer_base_addr/top_addr constants.
- Natural sub-module: rr_arb2, a 2-request round-robin arbiter instantiated once per slave.
- Remaining logic (decode, request buffers, per-master FSM, response mux) stays in mem_arbiter.

## Test plan
- Data read to dram_base_addr+0x10 while the instruction master is idle: s_valid[1] in the same cycle with s_addr = 0x10. Slave responds next cycle with 0xDEADBEEF; m_ready[1] in that cycle with m_rdata[1] = 0xDEADBEEF.
- Both masters hit iram in the same cycle after reset: data master is granted first. Instruction master issues the cycle after iram's s_ready. On the next double conflict the instruction master wins.
- Data write to uart (wstrb = 0xF), uart ready after 5 cycles; instruction fetch to uart 1 cycle later: the fetch stays PEND for 5 cycles, then issues with its buffered addr/wdata/wstrb intact.
- Instruction fetch to iram and data read to timer in the same cycle: both s_valid[0] and s_valid[3] assert in the same cycle.
- Data access to an unmapped address (0xFFFF_FFF0): no s_valid; m_ready[1] one cycle later with m_rdata = 0.
- rst = 0 while the data master is BUSY on uart: the following uart s_ready produces no m_ready. After reset a fresh data request issues immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared address map, slave indices and master FSM encoding for the
// two-master / four-slave memory arbiter.
package mem_arbiter_pkg;

  localparam int NSLV = 4;

  localparam int SLV_IRAM  = 0;
  localparam int SLV_DRAM  = 1;
  localparam int SLV_UART  = 2;
  localparam int SLV_TIMER = 3;

  localparam logic [31:0] iram_base_addr  = 32'h0010_0000;
  localparam logic [31:0] iram_top_addr   = 32'h0010_8000;
  localparam logic [31:0] dram_base_addr  = 32'h0020_0000;
  localparam logic [31:0] dram_top_addr   = 32'h0020_8000;
  localparam logic [31:0] uart_base_addr  = 32'h1000_0000;
  localparam logic [31:0] uart_top_addr   = 32'h1000_0100;
  localparam logic [31:0] timer_base_addr = 32'h1000_1000;
  localparam logic [31:0] timer_top_addr  = 32'h1000_1100;

  localparam logic [NSLV-1:0][31:0] slv_base_addr = {
    timer_base_addr, uart_base_addr, dram_base_addr, iram_base_addr
  };
  localparam logic [NSLV-1:0][31:0] slv_top_addr = {
    timer_top_addr, uart_top_addr, dram_top_addr, iram_top_addr
  };

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_PEND = 2'd1,
    M_BUSY = 2'd2,
    M_ERR  = 2'd3
  } mst_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } dec_t;

  // Later slaves overwrite earlier matches, giving timer > uart > dram > iram.
  function automatic dec_t addr_decode(input logic [31:0] addr);
    dec_t res;
    res = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (addr >= slv_base_addr[k] && addr < slv_top_addr[k]) begin
        res.hit = 1'b1;
        res.idx = 2'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin arbiter with its own last-grant bit; grants only
// while the owning slave is free (en).
module rr_arb2 (
  input  logic       clk_pll,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      if (|gnt) begin
        last_d = gnt[1];
      end
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Routes instruction/data master requests to iram/dram/uart/timer, holding
// each slave for one master until it responds and buffering blocked requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                  clk_pll,
  input  logic                  rst,
  input  logic [1:0]            m_valid,
  input  logic [1:0]            m_instr,
  input  logic [1:0][31:0]      m_addr,
  input  logic [1:0][31:0]      m_wdata,
  input  logic [1:0][3:0]       m_wstrb,
  output logic [1:0][31:0]      m_rdata,
  output logic [1:0]            m_ready,
  output logic [NSLV-1:0]       s_valid,
  output logic [NSLV-1:0]       s_instr,
  output logic [NSLV-1:0][31:0] s_addr,
  output logic [NSLV-1:0][31:0] s_wdata,
  output logic [NSLV-1:0][3:0]  s_wstrb,
  input  logic [NSLV-1:0][31:0] s_rdata,
  input  logic [NSLV-1:0]       s_ready
);

  mst_state_e [1:0] state_q;
  mst_state_e [1:0] state_d;

  logic [1:0]       buf_instr_q, buf_instr_d;
  logic [1:0][31:0] buf_addr_q, buf_addr_d;
  logic [1:0][31:0] buf_wdata_q, buf_wdata_d;
  logic [1:0][3:0]  buf_wstrb_q, buf_wstrb_d;

  logic [NSLV-1:0]  own_vld_q, own_vld_d;
  logic [NSLV-1:0]  own_id_q, own_id_d;

  logic [1:0]       sel_instr;
  logic [1:0][31:0] sel_addr;
  logic [1:0][31:0] sel_wdata;
  logic [1:0][3:0]  sel_wstrb;
  dec_t [1:0]       dec;
  logic [1:0]       req_act;

  logic [NSLV-1:0][1:0] slv_req;
  logic [NSLV-1:0][1:0] gnt;
  logic [1:0]           win;
  logic [1:0]           resp;

  // A pending master presents its buffered request; otherwise the live inputs.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      if (state_q[m] == M_PEND) begin
        sel_instr[m] = buf_instr_q[m];
        sel_addr[m]  = buf_addr_q[m];
        sel_wdata[m] = buf_wdata_q[m];
        sel_wstrb[m] = buf_wstrb_q[m];
      end else begin
        sel_instr[m] = m_instr[m];
        sel_addr[m]  = m_addr[m];
        sel_wdata[m] = m_wdata[m];
        sel_wstrb[m] = m_wstrb[m];
      end
      dec[m]     = addr_decode(sel_addr[m]);
      req_act[m] = dec[m].hit &&
                   ((state_q[m] == M_IDLE && m_valid[m]) || state_q[m] == M_PEND);
    end
  end

  generate
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
      assign slv_req[gi] = {req_act[1] && (dec[1].idx == 2'(gi)),
                            req_act[0] && (dec[0].idx == 2'(gi))};

      rr_arb2 u_arb (
        .clk_pll (clk_pll),
        .rst     (rst),
        .en      (!own_vld_q[gi]),
        .req     (slv_req[gi]),
        .gnt     (gnt[gi])
      );
    end
  endgenerate

  always_comb begin
    s_valid     = '0;
    s_instr     = '0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m_ready     = '0;
    m_rdata     = '0;
    own_vld_d   = own_vld_q;
    own_id_d    = own_id_q;
    win         = '0;
    resp        = '0;
    state_d     = state_q;
    buf_instr_d = buf_instr_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    buf_wstrb_d = buf_wstrb_q;

    for (int k = 0; k < NSLV; k++) begin
      if (|gnt[k]) begin
        s_valid[k]     = 1'b1;
        s_instr[k]     = sel_instr[gnt[k][1]];
        s_addr[k]      = sel_addr[gnt[k][1]] ^ slv_base_addr[k];
        s_wdata[k]     = sel_wdata[gnt[k][1]];
        s_wstrb[k]     = sel_wstrb[gnt[k][1]];
        own_vld_d[k]   = 1'b1;
        own_id_d[k]    = gnt[k][1];
        win[gnt[k][1]] = 1'b1;
      end
      // Grant needs owner = none and a response needs an owner, so these never overlap.
      if (s_ready[k] && own_vld_q[k]) begin
        m_ready[own_id_q[k]] = 1'b1;
        m_rdata[own_id_q[k]] = s_rdata[k];
        resp[own_id_q[k]]    = 1'b1;
        own_vld_d[k]         = 1'b0;
      end
    end

    for (int m = 0; m < 2; m++) begin
      case (state_q[m])
        M_IDLE: begin
          if (m_valid[m]) begin
            if (!dec[m].hit) begin
              state_d[m] = M_ERR;
            end else if (win[m]) begin
              state_d[m] = M_BUSY;
            end else begin
              state_d[m]     = M_PEND;
              buf_instr_d[m] = m_instr[m];
              buf_addr_d[m]  = m_addr[m];
              buf_wdata_d[m] = m_wdata[m];
              buf_wstrb_d[m] = m_wstrb[m];
            end
          end
        end
        M_PEND: begin
          if (win[m]) begin
            state_d[m] = M_BUSY;
          end
        end
        M_BUSY: begin
          if (resp[m]) begin
            state_d[m] = M_IDLE;
          end
        end
        M_ERR: begin
          m_ready[m] = 1'b1;
          m_rdata[m] = '0;
          state_d[m] = M_IDLE;
        end
        default: state_d[m] = M_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        state_q[m] <= M_IDLE;
      end
      buf_instr_q <= '0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      buf_wstrb_q <= '0;
      own_vld_q   <= '0;
      own_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_instr_q <= buf_instr_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      buf_wstrb_q <= buf_wstrb_d;
      own_vld_q   <= own_vld_d;
      own_id_q    <= own_id_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge,
// outputs are compared on the falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic                  clk_pll = 1'b0;
  logic                  rst;
  logic [1:0]            m_valid;
  logic [1:0]            m_instr;
  logic [1:0][31:0]      m_addr;
  logic [1:0][31:0]      m_wdata;
  logic [1:0][3:0]       m_wstrb;
  logic [1:0][31:0]      m_rdata;
  logic [1:0]            m_ready;
  logic [NSLV-1:0]       s_valid;
  logic [NSLV-1:0]       s_instr;
  logic [NSLV-1:0][31:0] s_addr;
  logic [NSLV-1:0][31:0] s_wdata;
  logic [NSLV-1:0][3:0]  s_wstrb;
  logic [NSLV-1:0][31:0] s_rdata;
  logic [NSLV-1:0]       s_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_pll = ~clk_pll;

  mem_arbiter dut (
    .clk_pll (clk_pll),
    .rst     (rst),
    .m_valid (m_valid),
    .m_instr (m_instr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_instr (s_instr),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    m_valid = '0;
    m_instr = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ready = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_pll);
    #1;
    clear_inputs();
  endtask

  task automatic sample();
    @(negedge clk_pll);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    sample();
    check("reset m_ready", 32'(m_ready), 32'h0);
    check("reset s_valid", 32'(s_valid), 32'h0);
    check("reset m_rdata0", m_rdata[0], 32'h0);

    // Uncontended dram read: zero-latency issue and combinational response.
    next_cycle();
    m_valid[1] = 1'b1;
    m_addr[1]  = dram_base_addr + 32'h10;
    sample();
    check("dram rd s_valid", 32'(s_valid), 32'h2);
    check("dram rd s_addr", s_addr[1], 32'h10);
    check("dram rd no early ready", 32'(m_ready), 32'h0);
    next_cycle();
    s_ready[1] = 1'b1;
    s_rdata[1] = 32'hDEAD_BEEF;
    sample();
    check("dram rd m_ready", 32'(m_ready), 32'h2);
    check("dram rd m_rdata", m_rdata[1], 32'hDEAD_BEEF);

    // Both masters to iram: data master wins first conflict after reset.
    next_cycle();
    m_valid   = 2'b11;
    m_instr   = 2'b01;
    m_addr[0] = iram_base_addr + 32'h4;
    m_addr[1] = iram_base_addr + 32'h8;
    sample();
    check("iram conflict s_valid", 32'(s_valid), 32'h1);
    check("iram conflict s_addr", s_addr[0], 32'h8);
    check("iram conflict s_instr", 32'(s_instr[0]), 32'h0);
    next_cycle();
    sample();
    check("iram busy no issue", 32'(s_valid), 32'h0);
    next_cycle();
    s_ready[0] = 1'b1;
    s_rdata[0] = 32'h0000_0011;
    sample();
    check("iram data m_ready", 32'(m_ready), 32'h2);
    check("iram data m_rdata", m_rdata[1], 32'h11);
    check("iram not regrant same cycle", 32'(s_valid), 32'h0);
    next_cycle();
    sample();
    check("iram pend issue s_valid", 32'(s_valid), 32'h1);
    check("iram pend issue s_addr", s_addr[0], 32'h4);
    check("iram pend issue s_instr", 32'(s_instr[0]), 32'h1);
    next_cycle();
    s_ready[0] = 1'b1;
    s_rdata[0] = 32'h0000_0022;
    sample();
    check("iram instr m_ready", 32'(m_ready), 32'h1);
    check("iram instr m_rdata", m_rdata[0], 32'h22);

    // dram last granted to data master, so instruction master wins this conflict.
    next_cycle();
    m_valid   = 2'b11;
    m_instr   = 2'b01;
    m_addr[0] = dram_base_addr + 32'h20;
    m_addr[1] = dram_base_addr + 32'h30;
    sample();
    check("dram conflict s_valid", 32'(s_valid), 32'h2);
    check("dram conflict s_addr", s_addr[1], 32'h20);
    check("dram conflict s_instr", 32'(s_instr[1]), 32'h1);
    next_cycle();
    s_ready[1] = 1'b1;
    s_rdata[1] = 32'h0000_0033;
    sample();
    check("dram instr m_ready", 32'(m_ready), 32'h1);
    check("dram instr m_rdata", m_rdata[0], 32'h33);
    next_cycle();
    sample();
    check("dram data issue s_valid", 32'(s_valid), 32'h2);
    check("dram data issue s_addr", s_addr[1], 32'h30);
    next_cycle();
    s_ready[1] = 1'b1;
    s_rdata[1] = 32'h0000_0044;
    sample();
    check("dram data m_ready", 32'(m_ready), 32'h2);
    check("dram data m_rdata", m_rdata[1], 32'h44);

    // Slow uart held by the data write; fetch pends 5 cycles from its buffer.
    next_cycle();
    m_valid[1] = 1'b1;
    m_addr[1]  = uart_base_addr + 32'h4;
    m_wdata[1] = 32'hA5A5_0001;
    m_wstrb[1] = 4'hF;
    sample();
    check("uart wr s_valid", 32'(s_valid), 32'h4);
    check("uart wr s_wdata", s_wdata[2], 32'hA5A5_0001);
    check("uart wr s_wstrb", 32'(s_wstrb[2]), 32'hF);
    next_cycle();
    m_valid[0] = 1'b1;
    m_instr[0] = 1'b1;
    m_addr[0]  = uart_base_addr + 32'h8;
    m_wdata[0] = 32'h1234_5678;
    sample();
    check("uart fetch pend", 32'(s_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      m_addr[0]  = 32'hFFFF_0000;
      m_wdata[0] = 32'hBAD0_BAD0;
      m_wstrb[0] = 4'h3;
      sample();
      check($sformatf("uart pend cycle %0d", i + 2), 32'(s_valid), 32'h0);
    end
    next_cycle();
    s_ready[2] = 1'b1;
    s_rdata[2] = 32'h0000_0055;
    sample();
    check("uart wr m_ready", 32'(m_ready), 32'h2);
    check("uart wr m_rdata", m_rdata[1], 32'h55);
    check("uart freed not regrant", 32'(s_valid), 32'h0);
    next_cycle();
    sample();
    check("uart fetch s_valid", 32'(s_valid), 32'h4);
    check("uart fetch s_addr", s_addr[2], 32'h8);
    check("uart fetch s_wdata", s_wdata[2], 32'h1234_5678);
    check("uart fetch s_wstrb", 32'(s_wstrb[2]), 32'h0);
    check("uart fetch s_instr", 32'(s_instr[2]), 32'h1);
    next_cycle();
    s_ready[2] = 1'b1;
    s_rdata[2] = 32'h0000_0066;
    sample();
    check("uart fetch m_ready", 32'(m_ready), 32'h1);
    check("uart fetch m_rdata", m_rdata[0], 32'h66);

    // Different slaves issue in parallel.
    next_cycle();
    m_valid   = 2'b11;
    m_instr   = 2'b01;
    m_addr[0] = iram_base_addr + 32'hC;
    m_addr[1] = timer_base_addr + 32'h4;
    sample();
    check("parallel s_valid", 32'(s_valid), 32'h9);
    check("parallel iram s_addr", s_addr[0], 32'hC);
    check("parallel timer s_addr", s_addr[3], 32'h4);
    next_cycle();
    s_ready    = 4'b1001;
    s_rdata[0] = 32'h0000_0077;
    s_rdata[3] = 32'h0000_0088;
    sample();
    check("parallel m_ready", 32'(m_ready), 32'h3);
    check("parallel m_rdata0", m_rdata[0], 32'h77);
    check("parallel m_rdata1", m_rdata[1], 32'h88);

    // Unmapped address errors out one cycle later with zero data.
    next_cycle();
    m_valid[1] = 1'b1;
    m_addr[1]  = 32'hFFFF_FFF0;
    sample();
    check("unmapped no s_valid", 32'(s_valid), 32'h0);
    check("unmapped no early ready", 32'(m_ready), 32'h0);
    next_cycle();
    sample();
    check("unmapped m_ready", 32'(m_ready), 32'h2);
    check("unmapped m_rdata", m_rdata[1], 32'h0);
    next_cycle();
    sample();
    check("unmapped single pulse", 32'(m_ready), 32'h0);

    // Reset while the data master owns uart drops the late response.
    next_cycle();
    m_valid[1] = 1'b1;
    m_addr[1]  = uart_base_addr;
    sample();
    check("pre-reset uart s_valid", 32'(s_valid), 32'h4);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    s_ready[2] = 1'b1;
    s_rdata[2] = 32'h0000_0099;
    sample();
    check("post-reset stale ready", 32'(m_ready), 32'h0);
    next_cycle();
    m_valid[1] = 1'b1;
    m_addr[1]  = uart_base_addr + 32'hC;
    sample();
    check("post-reset issue s_valid", 32'(s_valid), 32'h4);
    check("post-reset issue s_addr", s_addr[2], 32'hC);
    next_cycle();
    s_ready[2] = 1'b1;
    s_rdata[2] = 32'h0000_00AA;
    sample();
    check("post-reset m_ready", 32'(m_ready), 32'h2);
    check("post-reset m_rdata", m_rdata[1], 32'hAA);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
